quad_decoder: RTL and testbench

Quadrature front end for the position counter: it synchronises and glitch-filters two asynchronous encoder channels `a`/`b` and decodes each legal Gray-code phase change. Each legal change produces a single-cycle `step` pulse and a `updn` direction level. `step` qualifies the downstream 32-bit up/down counter and `updn` drives its direction input. Illegal double-edge transitions are flagged rather than counted.

---
 rtl/quad_pkg.sv | 32 +++
 rtl/quad_filter.sv | 50 +++++
 rtl/quad_decoder.sv | 139 +++++++++++++
 tb/tb_quad_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: phase encoding,
// decoder state enum and the Gray-code up-sequence helper.
package quad_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [7:0]  ERRCNT_MAX  = 8'd255;

  // Phase that follows p when the encoder turns in the up direction.
  function automatic phase_t next_up(input phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_01;
      PH_01:   n = PH_11;
      PH_11:   n = PH_10;
      default: n = PH_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: 2-flop synchroniser followed by a debounce filter that
// accepts a new level only after it has held for FILTER_LEN cycles.
module quad_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ch_i,
  output logic filt_o
);

  localparam int unsigned         CNT_W    = 4;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign level  = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (level != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ch_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters channels a/b, emits step/updn per legal Gray
// phase change and err on double-edge changes. QUAD_ERRCNT_EN adds err_count.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
`ifdef QUAD_ERRCNT_EN
  input  logic       err_clr,
  output logic [7:0] err_count,
`endif
  output logic       step,
  output logic       updn,
  output logic       err,
  output logic       ready
);

  localparam int unsigned            SETTLE_W    = 5;
  localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(FILTER_LEN + 2);

  logic                filt_a, filt_b;
  phase_t              ph, ph_diff;
  phase_t              prev_q, prev_d;
  dec_state_t          state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                settle_done;
  logic                step_q, step_d;
  logic                err_q, err_d;
  logic                updn_q, updn_d;
  logic                ready_q, ready_d;

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk    (clk),
    .rst    (rst),
    .ch_i   (a),
    .filt_o (filt_a)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk    (clk),
    .rst    (rst),
    .ch_i   (b),
    .filt_o (filt_b)
  );

  assign ph          = {filt_a, filt_b};
  assign ph_diff     = ph ^ prev_q;
  assign settle_done = (settle_q == SETTLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      settle_q <= '0;
      prev_q   <= PH_00;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      updn_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      err_q    <= err_d;
      updn_q   <= updn_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (settle_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // INIT captures the settled phase as the reference; RUN decodes against it.
  always_comb begin
    settle_d = settle_q;
    prev_d   = prev_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    updn_d   = updn_q;
    ready_d  = ready_q;
    case (state_q)
      INIT: begin
        ready_d = 1'b0;
        if (settle_done) begin
          prev_d  = ph;
          ready_d = 1'b1;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      default: begin
        if (ph_diff == 2'b11) begin
          err_d  = 1'b1;
          prev_d = ph;
        end else if (ph_diff != 2'b00) begin
          step_d = 1'b1;
          updn_d = (ph == next_up(prev_q));
          prev_d = ph;
        end
      end
    endcase
  end

  assign step  = step_q;
  assign err   = err_q;
  assign updn  = updn_q;
  assign ready = ready_q;

`ifdef QUAD_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Clear wins over a coincident err pulse; count sticks at ERRCNT_MAX.
  always_comb begin
    errcnt_d = errcnt_q;
    if (err_clr) begin
      errcnt_d = '0;
    end else if (err_q && (errcnt_q != ERRCNT_MAX)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a random walk
// checked cycle by cycle against a run-length / Gray-index reference model.
module tb_quad_decoder;

  localparam int unsigned FL  = 3;
  localparam int          LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic step, updn, err, ready;
`ifdef QUAD_ERRCNT_EN
  logic       err_clr = 1'b0;
  logic [7:0] err_count;
  int         m_errcnt = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] stim_q [$];
  logic       obs_step_q [$], obs_err_q [$], obs_updn_q [$];
  logic       exp_step_q [$], exp_err_q [$], exp_updn_q [$];
  logic [1:0] m_ph   = 2'b00;
  logic       m_updn = 1'b0;

  quad_decoder #(.FILTER_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
`ifdef QUAD_ERRCNT_EN
    .err_clr   (err_clr),
    .err_count (err_count),
`endif
    .step      (step),
    .updn      (updn),
    .err       (err),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  function automatic int ph_idx(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (up_seq[i] == p) return i;
    return 0;
  endfunction

  task automatic push_hold(input logic [1:0] p, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(p);
  endtask

  // Drive stim_q one entry per negedge; record outputs just before each drive.
  task automatic run_seq();
    obs_step_q.delete(); obs_err_q.delete(); obs_updn_q.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      obs_step_q.push_back(step);
      obs_err_q.push_back(err);
      obs_updn_q.push_back(updn);
      a = stim_q[i][1];
      b = stim_q[i][0];
    end
  endtask

  // A channel adopts a level once it has been driven FL entries in a row;
  // a phase change then shows up LAT entries after the last of those entries.
  task automatic model_seq();
    logic [1:0] acc = m_ph;
    logic [1:0] prev = m_ph;
    int         run_start [2] = '{-1, -1};
    int         n = stim_q.size();
    logic       cur = m_updn;
    logic       dir_at [$];
    exp_step_q.delete(); exp_err_q.delete(); exp_updn_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_step_q.push_back(1'b0);
      exp_err_q.push_back(1'b0);
      dir_at.push_back(1'b0);
    end
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < 2; c++) begin
        if (stim_q[j][c] != acc[c]) begin
          if (run_start[c] < 0) run_start[c] = j;
          if (j - run_start[c] + 1 == int'(FL)) begin
            acc[c] = stim_q[j][c];
            run_start[c] = -1;
          end
        end else begin
          run_start[c] = -1;
        end
      end
      if (acc != prev && j + LAT < n) begin
        if (acc == ~prev) exp_err_q[j+LAT] = 1'b1;
        else begin
          exp_step_q[j+LAT] = 1'b1;
          dir_at[j+LAT] = (ph_idx(acc) == (ph_idx(prev) + 1) % 4);
        end
      end
      prev = acc;
    end
    for (int k = 0; k < n; k++) begin
      if (exp_step_q[k]) cur = dir_at[k];
      exp_updn_q.push_back(cur);
`ifdef QUAD_ERRCNT_EN
      if (exp_err_q[k] && m_errcnt < 255) m_errcnt++;
`endif
    end
    m_updn = cur;
    m_ph   = acc;
  endtask

  task automatic test_reset();
    a = 1'b1; b = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({step, updn, err, ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", {step, updn, err, ready});
    end
`ifdef QUAD_ERRCNT_EN
    checks++;
    if (err_count !== 8'd0) begin
      failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_count);
    end
`endif
    rst = 1'b0;
    for (int i = 1; i <= int'(FL) + 13; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== (i >= int'(FL) + 3) || step !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL reset_init cyc=%0d ready/step/err got=%b%b%b exp=%b00",
                 i, ready, step, err, (i >= int'(FL) + 3));
      end
    end
    m_ph = 2'b11; m_updn = 1'b0;
  endtask

  task automatic test_up_down();
    int n_up = 0, n_dn = 0;
    stim_q.delete();
    push_hold(2'b01, 8); push_hold(2'b00, 8);
    push_hold(2'b01, 8); push_hold(2'b11, 8); push_hold(2'b10, 8); push_hold(2'b00, 8);
    push_hold(2'b10, 8); push_hold(2'b11, 8); push_hold(2'b01, 8); push_hold(2'b00, int'(FL) + 8);
    model_seq();
    run_seq();
    for (int i = 0; i < stim_q.size(); i++) begin
      checks++;
      if (obs_step_q[i] !== exp_step_q[i] || obs_err_q[i] !== exp_err_q[i] ||
          obs_updn_q[i] !== exp_updn_q[i]) begin
        failures++;
        $display("FAIL up_down idx=%0d step/err/updn got=%b%b%b exp=%b%b%b", i,
                 obs_step_q[i], obs_err_q[i], obs_updn_q[i], exp_step_q[i], exp_err_q[i], exp_updn_q[i]);
      end
      if (obs_step_q[i] === 1'b1) begin
        if (obs_updn_q[i] === 1'b1) n_up++; else n_dn++;
      end
    end
    checks++;
    if (n_up != 4 || n_dn != 6) begin
      failures++; $display("FAIL up_down_counts up=%0d dn=%0d exp up=4 dn=6", n_up, n_dn);
    end
    checks++;
    if (obs_step_q[22] !== 1'b1) begin
      failures++; $display("FAIL first_up_latency step@+6 got=%b exp=1", obs_step_q[22]);
    end
    checks++;
    if (obs_updn_q[stim_q.size()-1] !== 1'b0) begin
      failures++; $display("FAIL updn_hold got=%b exp=0", obs_updn_q[stim_q.size()-1]);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    stim_q.delete();
    push_hold(m_ph, 4);
    push_hold(m_ph ^ 2'b10, int'(FL) - 1);
    push_hold(m_ph, int'(FL) + 8);
    model_seq();
    run_seq();
    for (int i = 0; i < stim_q.size(); i++) begin
      checks++;
      if (obs_step_q[i] !== exp_step_q[i] || obs_err_q[i] !== exp_err_q[i] ||
          obs_updn_q[i] !== exp_updn_q[i]) begin
        failures++;
        $display("FAIL glitch idx=%0d step/err/updn got=%b%b%b exp=%b%b%b", i,
                 obs_step_q[i], obs_err_q[i], obs_updn_q[i], exp_step_q[i], exp_err_q[i], exp_updn_q[i]);
      end
      if (obs_step_q[i] !== 1'b0 || obs_err_q[i] !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL glitch_pulses got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_double_err();
    for (int pass = 0; pass < 2; pass++) begin
      int n_err = 0, n_step = 0;
      int toggles = (pass == 0) ? 1 : 299;
      stim_q.delete();
      push_hold(m_ph, 4);
      for (int t = 0; t < toggles; t++) push_hold(m_ph ^ ((t % 2 == 0) ? 2'b11 : 2'b00), 6);
      push_hold(stim_q[stim_q.size()-1], int'(FL) + 8);
      model_seq();
      run_seq();
      for (int i = 0; i < stim_q.size(); i++) begin
        checks++;
        if (obs_step_q[i] !== exp_step_q[i] || obs_err_q[i] !== exp_err_q[i] ||
            obs_updn_q[i] !== exp_updn_q[i]) begin
          failures++;
          $display("FAIL double_err p%0d idx=%0d step/err/updn got=%b%b%b exp=%b%b%b", pass, i,
                   obs_step_q[i], obs_err_q[i], obs_updn_q[i], exp_step_q[i], exp_err_q[i], exp_updn_q[i]);
        end
        if (obs_err_q[i] === 1'b1) n_err++;
        if (obs_step_q[i] === 1'b1) n_step++;
      end
      checks++;
      if (n_err != toggles || n_step != 0) begin
        failures++; $display("FAIL double_err_count p%0d err=%0d step=%0d exp err=%0d step=0",
                             pass, n_err, n_step, toggles);
      end
`ifdef QUAD_ERRCNT_EN
      checks++;
      if (err_count !== ((pass == 0) ? 8'd1 : 8'd255)) begin
        failures++; $display("FAIL errcnt_p%0d got=%0d exp=%0d", pass, err_count, (pass == 0) ? 1 : 255);
      end
`endif
    end
`ifdef QUAD_ERRCNT_EN
    begin
      bit seen = 1'b0;
      @(negedge clk);
      a = ~m_ph[1]; b = ~m_ph[0];
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (err === 1'b1) begin
          seen = 1'b1;
          err_clr = 1'b1;
          @(negedge clk);
          err_clr = 1'b0;
        end
      end
      checks++;
      if (!seen || err_count !== 8'd0) begin
        failures++; $display("FAIL errclr_priority seen=%0d got=%0d exp=0", seen, err_count);
      end
      repeat (int'(FL) + 8) @(negedge clk);
      m_ph = ~m_ph;
      m_errcnt = 0;
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0] cur = m_ph;
    stim_q.delete();
    push_hold(cur, 4);
    for (int m = 0; m < 60; m++) begin
      int r    = $urandom_range(0, 99);
      int hold = $urandom_range(int'(FL) + 1, int'(FL) + 6);
      if (r < 70) begin
        int dir = $urandom_range(0, 1);
        cur = up_seq[(ph_idx(cur) + (dir ? 1 : 3)) % 4];
        push_hold(cur, hold);
      end else if (r < 85) begin
        cur = ~cur;
        push_hold(cur, hold);
      end else begin
        int g = $urandom_range(1, int'(FL) - 1);
        push_hold(cur ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01), g);
        push_hold(cur, hold);
      end
    end
    push_hold(cur, int'(FL) + 8);
    model_seq();
    run_seq();
    for (int i = 0; i < stim_q.size(); i++) begin
      checks++;
      if (obs_step_q[i] !== exp_step_q[i] || obs_err_q[i] !== exp_err_q[i] ||
          obs_updn_q[i] !== exp_updn_q[i]) begin
        failures++;
        $display("FAIL random idx=%0d step/err/updn got=%b%b%b exp=%b%b%b", i,
                 obs_step_q[i], obs_err_q[i], obs_updn_q[i], exp_step_q[i], exp_err_q[i], exp_updn_q[i]);
      end
    end
`ifdef QUAD_ERRCNT_EN
    checks++;
    if (err_count !== 8'(m_errcnt)) begin
      failures++; $display("FAIL random_errcnt got=%0d exp=%0d", err_count, m_errcnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] nxt  = up_seq[(ph_idx(m_ph) + 1) % 4];
    logic [1:0] nxt2 = up_seq[(ph_idx(m_ph) + 2) % 4];
    stim_q.delete();
    push_hold(nxt, int'(FL) + 8);
    run_seq();
    checks++;
    if (updn !== 1'b1 || ready !== 1'b1) begin
      failures++; $display("FAIL pre_reset updn/ready got=%b%b exp=11", updn, ready);
    end
    @(negedge clk);
    a = nxt2[1]; b = nxt2[0];
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({step, updn, err, ready} !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_outputs got=%b exp=0000", {step, updn, err, ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= int'(FL) + 13; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== (i >= int'(FL) + 3) || step !== 1'b0 || err !== 1'b0 || updn !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_init cyc=%0d ready/step/err/updn got=%b%b%b%b exp=%b000",
                 i, ready, step, err, updn, (i >= int'(FL) + 3));
      end
    end
`ifdef QUAD_ERRCNT_EN
    checks++;
    if (err_count !== 8'd0) begin
      failures++; $display("FAIL mid_reset_errcnt got=%0d exp=0", err_count);
    end
    m_errcnt = 0;
`endif
    m_ph = nxt2; m_updn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_glitch();
    test_double_err();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
